// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding, default byte width and the
// parity-mode constants used by both the transmitter and the TX arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StBusy = 2'd2
  } arb_state_e;

  localparam int unsigned DATA_W_DEF = 8;

  // Parity mode select: even, odd, forced one, forced zero.
  localparam logic [1:0] E_P = 2'd0;
  localparam logic [1:0] O_P = 2'd1;
  localparam logic [1:0] P_1 = 2'd2;
  localparam logic [1:0] P_0 = 2'd3;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter-side bundle of the shared UART TX arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = DATA_W_DEF
);
  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        ack;
  logic [NUM_REQ-1:0]        done;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_send;
  logic                      tx_busy;
  logic [IdxW-1:0]           owner;
  logic                      err;
  logic                      err_clr;

  modport master (
    output req, req_data, tx_busy, err_clr,
    input  ack, done, tx_data, tx_send, owner, err
  );

  modport slave (
    input  req, req_data, tx_busy, err_clr,
    output ack, done, tx_data, tx_send, owner, err
  );

endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or above ptr_i, wrapping around.
// Purely combinational (rotate, find-first-set, unrotate).
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    ptr_i,
  output logic               valid_o,
  output logic [IdxW-1:0]    idx_o
);
  localparam logic [IdxW:0] NumReqW = (IdxW+1)'(NUM_REQ);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [IdxW-1:0]      off;
  logic [IdxW:0]        sum;

  always_comb begin
    dbl = {req_i, req_i} >> ptr_i;
    rot = dbl[NUM_REQ-1:0];
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IdxW'(i);
    end
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= NumReqW) sum = sum - NumReqW;
    valid_o = |req_i;
    idx_o   = sum[IdxW-1:0];
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte producers: round-robin grant,
// byte latch, send/busy tracking through one frame and per-owner completion.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned START_TO = 2048
) (
  input logic             clk,
  input logic             rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = $clog2(START_TO + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(START_TO - 1);

  arb_state_e         state_q, state_d;
  logic               tx_send_q, tx_send_d;
  logic [DATA_W-1:0]  tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [IdxW-1:0]    owner_q, owner_d;
  logic               err_q, err_d;
  logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

  logic               pick_valid;
  logic [IdxW-1:0]    pick_idx;
  logic [IdxW-1:0]    next_ptr;
  logic               err_set;

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_pick (
    .req_i  (bus.req),
    .ptr_i  (rr_ptr_q),
    .valid_o(pick_valid),
    .idx_o  (pick_idx)
  );

  assign next_ptr = (owner_q == IdxW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    tx_send_d = tx_send_q;
    tx_data_d = tx_data_q;
    ack_d     = '0;
    done_d    = '0;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    err_set   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A busy transmitter here is stale or stuck; hold off granting.
        if (!bus.tx_busy && pick_valid) begin
          tx_data_d       = bus.req_data[pick_idx*DATA_W +: DATA_W];
          ack_d[pick_idx] = 1'b1;
          tx_send_d       = 1'b1;
          owner_d         = pick_idx;
          cnt_d           = '0;
          state_d         = StSend;
        end
      end
      StSend: begin
        if (bus.tx_busy) begin
          tx_send_d = 1'b0;
          cnt_d     = '0;
          state_d   = StBusy;
        end else if (cnt_q == CntMax) begin
          tx_send_d = 1'b0;
          err_set   = 1'b1;
          rr_ptr_d  = next_ptr;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StBusy: begin
        if (!bus.tx_busy) begin
          done_d[owner_q] = 1'b1;
          rr_ptr_d        = next_ptr;
          state_d         = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    err_d = err_set | (err_q & ~bus.err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      tx_send_q <= 1'b0;
      tx_data_q <= '0;
      ack_q     <= '0;
      done_q    <= '0;
      owner_q   <= '0;
      err_q     <= 1'b0;
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      tx_send_q <= tx_send_d;
      tx_data_q <= tx_data_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      owner_q   <= owner_d;
      err_q     <= err_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.ack     = ack_q;
  assign bus.done    = done_q;
  assign bus.tx_data = tx_data_q;
  assign bus.tx_send = tx_send_q;
  assign bus.owner   = owner_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: per-cycle reference model, a table of
// single-grant vectors, hand-written corner sequences and a randomized phase.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 2048;

  logic clk = 1'b0;
  logic rst;

  uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ (N),
    .DATA_W  (DW),
    .START_TO(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model state, in terms of the arbiter's externally visible job.
  int            m_phase;  // 0 free, 1 waiting for busy to rise, 2 frame in flight
  int            m_age;
  int            m_ptr;
  int            m_owner;
  logic [DW-1:0] m_data;
  logic          m_err;

  logic            p_rst, p_busy, p_clr;
  logic [N-1:0]    p_req;
  logic [N*DW-1:0] p_data;

  int last_ack, last_done;

  // Transmitter model.
  int tx_mode;  // 0 normal, 1 never busy, 2 manual
  bit tx_act, tx_rnd;
  int tx_cnt, tx_dly, tx_len;

  typedef struct {
    logic [N-1:0]  req;
    int            exp_owner;
    logic [DW-1:0] exp_data;
  } vec_t;
  vec_t vt[9];

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic int pick(logic [N-1:0] r, int ptr);
    for (int i = 0; i < N; i++) begin
      int k;
      k = (ptr + i) % N;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  function automatic int oh_idx(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_and_check();
    logic [N-1:0] e_ack, e_done;
    bit set;
    int w;
    e_ack = '0;
    e_done = '0;
    set = 0;
    if (p_rst) begin
      m_phase = 0; m_age = 0; m_ptr = 0; m_owner = 0; m_data = '0; m_err = 0;
    end else begin
      case (m_phase)
        0: if (!p_busy && p_req != '0) begin
          w = pick(p_req, m_ptr);
          e_ack[w] = 1'b1;
          m_owner = w;
          m_data = p_data[w*DW +: DW];
          m_phase = 1;
          m_age = 0;
        end
        1: if (p_busy) m_phase = 2;
           else if (m_age == TO - 1) begin
             m_phase = 0; set = 1; m_ptr = (m_owner + 1) % N;
           end else m_age++;
        default: if (!p_busy) begin
          e_done[m_owner] = 1'b1;
          m_ptr = (m_owner + 1) % N;
          m_phase = 0;
        end
      endcase
      if (set) m_err = 1'b1;
      else if (p_clr) m_err = 1'b0;
    end
    chk("m_ack", 32'(bus.ack), 32'(e_ack));
    chk("m_done", 32'(bus.done), 32'(e_done));
    chk("m_tx_send", 32'(bus.tx_send), 32'(m_phase == 1));
    chk("m_tx_data", 32'(bus.tx_data), 32'(m_data));
    chk("m_owner", 32'(bus.owner), 32'(m_owner));
    chk("m_err", 32'(bus.err), 32'(m_err));
  endtask

  task automatic tx_step();
    if (tx_mode == 1) bus.tx_busy = 1'b0;
    else if (tx_mode == 0) begin
      if (!tx_act && bus.tx_send) begin
        tx_act = 1;
        tx_cnt = 0;
        if (tx_rnd) begin
          tx_dly = $urandom_range(1, 6);
          tx_len = $urandom_range(1, 8);
        end
      end
      if (tx_act) begin
        tx_cnt++;
        bus.tx_busy = (tx_cnt >= tx_dly) && (tx_cnt < tx_dly + tx_len);
        if (tx_cnt >= tx_dly + tx_len) tx_act = 0;
      end
    end
  endtask

  task automatic tick();
    p_rst = rst; p_req = bus.req; p_data = bus.req_data;
    p_busy = bus.tx_busy; p_clr = bus.err_clr;
    @(posedge clk);
    #1;
    model_and_check();
    last_ack = oh_idx(bus.ack);
    last_done = oh_idx(bus.done);
    tx_step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.err_clr = 1'b0;
    tx_act = 0;
    bus.tx_busy = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_ack(int budget, output int idx);
    idx = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (last_ack >= 0) begin
        idx = last_ack;
        break;
      end
    end
  endtask

  task automatic wait_done(int budget, output int idx);
    idx = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (last_done >= 0) begin
        idx = last_done;
        break;
      end
    end
  endtask

  initial begin
    int idx, sends, guard;
    logic [N-1:0] r;
    logic [N-1:0] order_req;
    int exp_order[5];

    vt[0] = '{4'b0010, 1, 8'hA5};
    vt[1] = '{4'b1111, 2, 8'h96};
    vt[2] = '{4'b1111, 3, 8'h3C};
    vt[3] = '{4'b1111, 0, 8'h11};
    vt[4] = '{4'b1111, 1, 8'hA5};
    vt[5] = '{4'b0101, 2, 8'h96};
    vt[6] = '{4'b0101, 0, 8'h11};
    vt[7] = '{4'b1000, 3, 8'h3C};
    vt[8] = '{4'b1001, 0, 8'h11};
    exp_order = '{0, 1, 2, 3, 0};

    tx_mode = 0; tx_rnd = 0; tx_dly = 3; tx_len = 20; tx_act = 0;
    bus.req = '0;
    bus.req_data = {8'h3C, 8'h96, 8'hA5, 8'h11};
    bus.tx_busy = 1'b0;
    bus.err_clr = 1'b0;
    rst = 1'b1;

    // Reset values.
    do_reset();
    chk("rst_tx_send", 32'(bus.tx_send), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst_ack_done", 32'({bus.ack, bus.done}), 32'd0);
    chk("rst_owner_err", 32'({bus.owner, bus.err}), 32'd0);

    // Single request, busy rises three cycles after send and lasts 20 cycles.
    bus.req = 4'b0010;
    tick();
    chk("single_ack", 32'(bus.ack), 32'h2);
    chk("single_data", 32'(bus.tx_data), 32'hA5);
    bus.req = '0;
    sends = 0; guard = 0;
    while (bus.tx_send === 1'b1 && guard < 50) begin
      sends++; tick(); guard++;
    end
    chk("single_send_cycles", 32'(sends), 32'd3);
    wait_done(60, idx);
    chk("single_done", 32'(idx), 32'd1);
    chk("single_owner", 32'(bus.owner), 32'd1);

    // Table of single grants from a fresh round-robin pointer.
    do_reset();
    tx_dly = 2; tx_len = 5;
    for (int i = 0; i < 9; i++) begin
      bus.req = vt[i].req;
      wait_ack(20, idx);
      chk("vec_ack", 32'(idx), 32'(vt[i].exp_owner));
      chk("vec_data", 32'(bus.tx_data), 32'(vt[i].exp_data));
      bus.req = '0;
      wait_done(40, idx);
      chk("vec_done", 32'(idx), 32'(vt[i].exp_owner));
    end

    // All requesters held high: strict rotation with wrap.
    do_reset();
    tx_dly = 2; tx_len = 4;
    order_req = 4'b1111;
    bus.req = order_req;
    for (int i = 0; i < 5; i++) begin
      wait_ack(40, idx);
      chk("contend_order", 32'(idx), 32'(exp_order[i]));
    end
    bus.req = '0;
    wait_done(40, idx);

    // Transmitter never goes busy: timeout, sticky error, next request served.
    do_reset();
    tx_mode = 1;
    bus.req = 4'b0001;
    wait_ack(5, idx);
    chk("to_ack", 32'(idx), 32'd0);
    bus.req = '0;
    sends = 0; guard = 0;
    while (bus.tx_send === 1'b1 && guard < 3000) begin
      sends++; tick(); guard++;
    end
    chk("to_send_cycles", 32'(sends), 32'(TO));
    chk("to_err", 32'(bus.err), 32'd1);
    tx_mode = 0; tx_dly = 2; tx_len = 3;
    bus.req = 4'b0011;
    wait_ack(5, idx);
    chk("to_next_grant", 32'(idx), 32'd1);
    bus.req = '0;
    wait_done(30, idx);
    chk("to_err_held", 32'(bus.err), 32'd1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("to_err_clr", 32'(bus.err), 32'd0);

    // Reset while a frame is in flight.
    do_reset();
    tx_dly = 2; tx_len = 30;
    bus.req = 4'b0100;
    wait_ack(5, idx);
    bus.req = '0;
    guard = 0;
    while (bus.tx_send === 1'b1 && guard < 20) begin
      tick(); guard++;
    end
    repeat (3) tick();
    rst = 1'b1;
    bus.req = 4'b1000;
    tx_act = 0;
    bus.tx_busy = 1'b0;
    tick();
    chk("midrst_send", 32'(bus.tx_send), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    tx_dly = 2; tx_len = 3;
    tick();
    chk("midrst_grant", 32'(last_ack), 32'd3);
    bus.req = '0;
    wait_done(30, idx);

    // Transmitter busy while idle blocks any grant.
    do_reset();
    tx_mode = 2;
    bus.tx_busy = 1'b1;
    bus.req = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stuck_no_ack", 32'(bus.ack), 32'd0);
    end
    bus.tx_busy = 1'b0;
    tx_mode = 0;
    tick();
    chk("stuck_ack", 32'(bus.ack), 32'h1);
    bus.req = '0;
    wait_done(30, idx);

    // Randomized traffic against the model.
    do_reset();
    tx_rnd = 1;
    for (int c = 0; c < 4000; c++) begin
      r = bus.req;
      for (int j = 0; j < N; j++) begin
        if (!r[j] && $urandom_range(0, 7) == 0) begin
          bus.req_data[j*DW +: DW] = DW'($urandom);
          r[j] = 1'b1;
        end else if (r[j] && $urandom_range(0, 63) == 0) begin
          r[j] = 1'b0;
        end
      end
      bus.req = r;
      bus.err_clr = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        tx_act = 0;
        bus.tx_busy = 1'b0;
      end else rst = 1'b0;
      tick();
      if (last_ack >= 0) bus.req[last_ack] = 1'b0;
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter between NUM_REQ byte producers (RX echo path, status reporter, host command responder, etc.). It arbitrates requests round-robin, latches the winner's byte and drives the transmitter's send/data inputs. It then tracks the transmitter's busy flag through one frame and reports completion to the owning requester. It sits between the requesters and TX in the 5 MHz clock domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, transmit byte width; must match the TX data width
START_TO, 2048, cycles to wait in SEND for tx_busy to rise before declaring an error (covers the 1024-cycle send sampling in the top level)

Ports:
clk  in  1  system clock (5 MHz domain)
rst  in  1  synchronous, active-high reset
req  in  NUM_REQ  request per requester; held high until matching ack
req_data  in  NUM_REQ*DATA_W  packed bytes; requester i uses bits [i*DATA_W +: DATA_W]
ack  out  NUM_REQ  one-cycle pulse: byte latched, requester may change data / drop req
done  out  NUM_REQ  one-cycle pulse to owner when its frame has finished
tx_data  out  DATA_W  byte to transmitter, stable from grant until done
tx_send  out  1  start request to transmitter
tx_busy  in  1  transmitter busy (high for whole frame)
owner  out  clog2(NUM_REQ)  index of current/last granted requester
err  out  1  sticky: tx_busy never rose within START_TO cycles
err_clr  in  1  clears err

Behaviour:
- All outputs registered. On reset: state=IDLE, tx_send=0, tx_data=0, ack=0, done=0, owner=0, err=0, rr_ptr=0 (requester 0 has top priority), timeout count=0.
- States: IDLE, SEND, BUSY.
- IDLE: grants only when tx_busy=0 and req is nonzero. Winner = first set bit searching from rr_ptr upward with wrap-around. At that edge: tx_data<=winner's slice, ack[winner]=1 for one cycle, tx_send<=1, owner<=winner, state->SEND. Latency: req sampled at edge k produces ack, tx_data and tx_send at edge k+1.
- If tx_busy=1 in IDLE (stale or stuck), no grant.
- SEND: tx_send held at 1; timeout counter increments.
  - If tx_busy=1: tx_send<=0, counter cleared, state->BUSY.
  - Else if counter reaches START_TO-1: tx_send<=0, err<=1, rr_ptr<=owner+1 mod NUM_REQ, state->IDLE. No done is issued; the byte is dropped.
- BUSY: wait for tx_busy=0. Then done[owner]=1 for one cycle, rr_ptr<=owner+1 mod NUM_REQ, state->IDLE. The earliest next grant is the following edge.
- ack and done never assert for more than one bit or more than one cycle. ack and done never assert in the same cycle.
- req deasserted before ack: that request is simply not seen; no error.
- The owner may re-raise req right after ack. It is served no earlier than after its done, and only if no other requester is pending ahead of it in round-robin order.
- tx_data holds its value in all states until the next grant.
- err_clr with a simultaneous timeout: set wins. err_clr otherwise clears err at the next edge.
- rst in any state: returns to reset values at the next edge. tx_send drops immediately, no done is issued, and any in-flight frame is abandoned.
- rr_ptr wrap: owner=NUM_REQ-1 sets rr_ptr=0.

Decomposition:
- Shared package uart_pkg holds:
  - state encodings IDLE/SEND/BUSY
  - DATA_W default
  - the existing parity constants E_P, O_P, P_1, P_0, so TX and arbiter share one definition
- One natural sub-module, rr_pick: combinational. Takes req and rr_ptr, returns a valid flag and the winner index (rotate, find-first-set, unrotate).

Test Plan:
- Single request: req=4'b0010, req_data[15:8]=8'hA5, TX model raises busy 3 cycles after send for 20 cycles → ack[1] at edge+1, tx_data=A5, tx_send high 3 cycles, done[1] one cycle after busy falls, owner=1.
- Contention: req=4'b1111 held, re-raised after each ack → grants in order 0,1,2,3,0 with rr_ptr wrap; no double grant.
- Priority rotation: after serving req 2, assert req=4'b0101 → requester 0 loses to nothing above 2, so it is granted only after requester 3 and wrap. Expected: with req=4'b0101, grant 0, then 2.
- Timeout: TX model never raises busy; req=4'b0001 → tx_send high exactly 2048 cycles, err=1, no done, next request still granted. err_clr pulse → err=0.
- Reset mid-frame: assert rst during BUSY → next edge tx_send=0, state IDLE, no done; after release, pending req=4'b1000 granted first with rr_ptr=0 search.
- Busy stuck: tx_busy=1 while IDLE with req=4'b0001 → no ack until tx_busy=0, then ack on the following edge.
